// File: rtl/axis_arb_pkg.sv
// Shared types for the packet-level round-robin stream arbiter:
// FSM state encoding and the source-index width helper.
package axis_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Bits needed to index n sources; never less than one.
  function automatic int src_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry output register with valid/ready handshake; accepts a new
// beat every cycle while the downstream keeps ready high.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Payload only moves on an accepted beat, so it holds while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC AXI-Stream sources
// into one output stream through a registered slice.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int N_SRC   = 4,
  localparam int SRC_W  = src_w(N_SRC),
  localparam int KEEP_W = DATA_WD / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         s_valid,
  output logic [N_SRC-1:0]         s_ready,
  input  logic [N_SRC*DATA_WD-1:0] s_data,
  input  logic [N_SRC*KEEP_W-1:0]  s_keep,
  input  logic [N_SRC-1:0]         s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WD-1:0]       m_data,
  output logic [KEEP_W-1:0]        m_keep,
  output logic                     m_last,
  output logic [SRC_W-1:0]         m_src,
  output logic                     busy,
  output arb_state_e               dbg_state_o
);

  localparam int SLICE_W = DATA_WD + KEEP_W + 1 + SRC_W;

  // Handshake: a beat transfers on a rising edge where valid & ready are both
  // high; valid never waits on ready, and payload is held while valid & ~ready.
  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] grant_q, grant_d;

  logic             found;
  logic [SRC_W-1:0] pick;
  int               idx;

  logic               slice_in_valid;
  logic               slice_in_ready;
  logic [SLICE_W-1:0] slice_in_data;
  logic [SLICE_W-1:0] slice_out_data;

  // Rotating priority: first requester after the last packet's owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(ptr_q) + k) % N_SRC;
      if (!found && s_valid[idx]) begin
        found = 1'b1;
        pick  = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    s_ready        = '0;
    slice_in_valid = 1'b0;
    case (state_q)
      ARB: begin
        if (found) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        s_ready[grant_q] = slice_in_ready;
        slice_in_valid   = s_valid[grant_q];
        if (s_valid[grant_q] && slice_in_ready && s_last[grant_q]) begin
          ptr_d   = grant_q;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= SRC_W'(N_SRC - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign slice_in_data = {s_data[int'(grant_q)*DATA_WD +: DATA_WD],
                          s_keep[int'(grant_q)*KEEP_W +: KEEP_W],
                          s_last[grant_q],
                          grant_q};

  axis_reg_slice #(
    .W(SLICE_W)
  ) u_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (slice_in_valid),
    .in_ready_o (slice_in_ready),
    .in_data_i  (slice_in_data),
    .out_valid_o(m_valid),
    .out_ready_i(m_ready),
    .out_data_o (slice_out_data)
  );

  assign {m_data, m_keep, m_last, m_src} = slice_out_data;
  assign busy        = (state_q == XFER);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source packet drivers, expected
// beats queued in grant order, and a monitor that pops on every output beat.
module tb_axis_rr_arbiter;
  import axis_arb_pkg::*;

  localparam int DW    = 32;
  localparam int NS    = 4;
  localparam int SW    = 2;
  localparam int KW    = DW / 8;
  localparam int EW    = SW + 1 + KW + DW;
  localparam int LIMIT = 300;

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready;
  logic [NS*DW-1:0]  s_data;
  logic [NS*KW-1:0]  s_keep;
  logic [NS-1:0]     s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [KW-1:0]     m_keep;
  logic              m_last;
  logic [SW-1:0]     m_src;
  logic              busy;
  arb_state_e        dbg_state;

  logic              src_valid[NS];
  logic [DW-1:0]     src_data[NS];
  logic [KW-1:0]     src_keep[NS];
  logic              src_last[NS];

  logic [EW-1:0] exp_q[$];
  int            pop_cyc[$];
  int            tests;
  int            fails;
  int            cyc;
  logic [EW-1:0] act_beat;
  logic [EW-1:0] exp_beat;
  logic          done0;

  axis_rr_arbiter #(.DATA_WD(DW), .N_SRC(NS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_keep     (s_keep),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .m_src      (m_src),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      s_valid[i]           = src_valid[i];
      s_data[i*DW +: DW]   = src_data[i];
      s_keep[i*KW +: KW]   = src_keep[i];
      s_last[i]            = src_last[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = 1'b0;
      src_data[i]  = '0;
      src_keep[i]  = '0;
      src_last[i]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_m_keep_last_src", 64'({m_keep, m_last, m_src}), 64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    rst_n = 1'b1;
  endtask

  // driver: one packet from one source; gap_len cycles of idle valid before beat gap_at
  task automatic send_pkt(input int src, input logic [DW-1:0] base, input int n,
                          input int gap_at, input int gap_len);
    logic acc;
    int   guard;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        src_valid[src] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      src_valid[src] = 1'b1;
      src_data[src]  = base + DW'(b);
      src_keep[src]  = (b == n - 1) ? 4'h3 : 4'hF;
      src_last[src]  = (b == n - 1);
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < LIMIT) begin
        @(negedge clk);
        acc = s_ready[src];
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout src=%0d beat=%0d act=no_accept exp=accept", src, b);
        b = n;
      end
    end
    src_valid[src] = 1'b0;
    src_last[src]  = 1'b0;
  endtask

  task automatic push_pkt(input int src, input logic [DW-1:0] base, input int n);
    logic [SW-1:0] s;
    logic [KW-1:0] k;
    s = SW'(src);
    for (int b = 0; b < n; b++) begin
      k = (b == n - 1) ? 4'h3 : 4'hF;
      exp_q.push_back({s, (b == n - 1), k, base + DW'(b)});
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || m_valid) && guard < LIMIT) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      act_beat = {m_src, m_last, m_keep, m_data};
      tests++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat act=%0h exp=none", act_beat);
      end else begin
        exp_beat = exp_q.pop_front();
        if (act_beat !== exp_beat) begin
          fails++;
          $display("FAIL beat act=%0h exp=%0h", act_beat, exp_beat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tests   = 0;
    fails   = 0;
    cyc     = 0;
    done0   = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b0;

    // single 3-beat packet from source 2
    do_reset();
    pop_cyc.delete();
    push_pkt(2, 32'hA0, 3);
    send_pkt(2, 32'hA0, 3, -1, 0);
    wait_drain("t1_drain");
    check("t1_back_to_back", 64'(pop_cyc.size() >= 3 ? pop_cyc[2] - pop_cyc[0] : -1), 64'd2);
    check("t1_busy_after", 64'(busy), 64'd0);

    // all sources requesting: grant order 0,1,2,3,0
    do_reset();
    push_pkt(0, 32'h100, 2);
    push_pkt(1, 32'h110, 2);
    push_pkt(2, 32'h120, 2);
    push_pkt(3, 32'h130, 2);
    push_pkt(0, 32'h140, 2);
    fork
      begin
        send_pkt(0, 32'h100, 2, -1, 0);
        send_pkt(0, 32'h140, 2, -1, 0);
      end
      send_pkt(1, 32'h110, 2, -1, 0);
      send_pkt(2, 32'h120, 2, -1, 0);
      send_pkt(3, 32'h130, 2, -1, 0);
    join
    wait_drain("t2_drain");
    check("t2_busy_after", 64'(busy), 64'd0);

    // downstream stall mid-packet from source 1
    do_reset();
    push_pkt(1, 32'h10, 4);
    fork
      send_pkt(1, 32'h10, 4, -1, 0);
      begin
        int guard;
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!m_valid && guard < LIMIT);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t3_stall_valid", 64'(m_valid), 64'd1);
          check("t3_stall_data", 64'(m_data), 64'h11);
          check("t3_stall_sready", 64'(s_ready[1]), 64'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // source 0 gaps mid-packet; source 3 waits for its last
    do_reset();
    push_pkt(0, 32'h20, 3);
    push_pkt(3, 32'h30, 2);
    done0 = 1'b0;
    fork
      begin
        send_pkt(0, 32'h20, 3, 1, 3);
        done0 = 1'b1;
      end
      send_pkt(3, 32'h30, 2, -1, 0);
      begin
        int guard;
        guard = 0;
        while (!done0 && guard < LIMIT) begin
          @(negedge clk);
          check("t4_sready3_blocked", 64'(s_ready[3]), 64'd0);
          guard++;
        end
      end
    join
    wait_drain("t4_drain");

    // reset in the middle of a source 1 packet
    do_reset();
    m_ready = 1'b0;
    src_valid[1] = 1'b1;
    src_data[1]  = 32'hB0;
    src_keep[1]  = 4'hF;
    src_last[1]  = 1'b0;
    begin
      int guard;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!s_ready[1] && guard < LIMIT);
    end
    @(posedge clk);
    #1;
    src_data[1] = 32'hB1;
    @(negedge clk);
    check("t5_held_data", 64'(m_data), 64'hB0);
    check("t5_full_sready", 64'(s_ready[1]), 64'd0);
    check("t5_busy_mid", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    src_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_m_valid", 64'(m_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_m_src", 64'(m_src), 64'd0);
    m_ready = 1'b1;
    push_pkt(0, 32'hC0, 1);
    push_pkt(1, 32'hB1, 2);
    fork
      send_pkt(0, 32'hC0, 1, -1, 0);
      send_pkt(1, 32'hB1, 2, -1, 0);
      rst_n = 1'b1;
    join
    wait_drain("t5_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter DATA_WD, default 32, data width per beat in bits, multiple of 8.
REQ-002 Parameter N_SRC, default 4, number of upstream stream sources, 2..8.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 s_valid  input  N_SRC  per-source beat valid.
REQ-006 s_ready  output  N_SRC  per-source beat accept.
REQ-007 s_data  input  N_SRC*DATA_WD  per-source beat data; source i occupies bits [i*DATA_WD +: DATA_WD].
REQ-008 s_keep  input  N_SRC*DATA_WD/8  per-source byte enables.
REQ-009 s_last  input  N_SRC  per-source end-of-packet flag.
REQ-010 m_valid  output  1  output beat valid.
REQ-011 m_ready  input  1  downstream accept.
REQ-012 m_data  output  DATA_WD  output beat data.
REQ-013 m_keep  output  DATA_WD/8  output byte enables.
REQ-014 m_last  output  1  output end-of-packet flag.
REQ-015 m_src  output  SRC_W  index of the source that produced the current output beat; SRC_W = clog2(N_SRC).
REQ-016 busy  output  1  high while a packet grant is held.

Function
REQ-017 The block SHALL share one output stream among N_SRC sources at packet granularity; packets are never interleaved.
REQ-018 FSM states SHALL be ARB and XFER.
REQ-019 In ARB with any s_valid high, the block SHALL select the first requester found scanning ptr+1, ptr+2, ... mod N_SRC, register it as grant, and enter XFER next cycle.
REQ-020 In ARB, all s_ready SHALL be 0 and no beat is accepted.
REQ-021 In ARB with s_valid all zero, the block SHALL remain in ARB.
REQ-022 In XFER, s_ready[grant] SHALL equal the output slice ready; all other s_ready bits SHALL be 0.
REQ-023 Output slice ready SHALL be ~m_valid | m_ready, allowing one beat per cycle under continuous m_ready.
REQ-024 A beat is accepted when s_valid[grant] & s_ready[grant]; its data, keep, last and grant SHALL appear on m_* exactly one cycle later.
REQ-025 m_data, m_keep, m_last and m_src SHALL hold stable while m_valid & ~m_ready.
REQ-026 In XFER, s_valid[grant] low SHALL NOT release the grant; the block waits.
REQ-027 An accepted beat with s_last high SHALL set ptr <= grant and return the FSM to ARB next cycle.
REQ-028 A single-beat packet (s_last on first beat) SHALL be handled identically.
REQ-029 One idle arbitration cycle SHALL separate consecutive packets on the input side.
REQ-030 busy SHALL be 1 exactly in XFER.
REQ-031 With all sources continuously requesting, grant order SHALL be 0,1,2,...,N_SRC-1,0,...

Reset
REQ-032 On rst_n low: FSM=ARB, ptr=N_SRC-1 (source 0 first priority), grant=0, m_valid=0, m_data=0, m_keep=0, m_last=0, m_src=0, busy=0.
REQ-033 Reset mid-packet SHALL discard the grant and any beat held in the slice; the remainder of the interrupted packet is treated by the FSM as a new packet.

Structure
REQ-034 A shared package axis_arb_pkg SHALL hold the FSM state typedef and the SRC_W width function.
REQ-035 The output register SHALL be one sub-module, axis_reg_slice, parameterised by width and carrying {data, keep, last, src} with a valid/ready interface.

Verification
REQ-036 Reset, then source 2 sends 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2), m_ready=1 -> m_data 0xA0..0xA2 on consecutive cycles, m_src=2, m_last only on 0xA2, busy drops after last.
REQ-037 All 4 sources valid with 2-beat packets, m_ready=1 -> m_src packet order 0,1,2,3,0; no interleaving.
REQ-038 Grant to source 1; m_ready=0 for 5 cycles mid-packet -> m_data stable, s_ready[1]=0 after slice fills, no beat lost or duplicated.
REQ-039 Source 0 drops s_valid for 3 cycles mid-packet while source 3 requests -> grant held on 0, s_ready[3]=0, source 3 served only after source 0's last.
REQ-040 Assert rst_n=0 mid-packet from source 1 -> next cycle m_valid=0, busy=0, m_src=0; after release source 0 wins if requesting.
